hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: max consecutive bus-wait cycles before forced release.
REQ-002 Parameter CNT_W, default 32: stall counter width.
REQ-003 cpu_clk in 1: sole clock, all state updates on rising edge.
REQ-004 cpu_rst in 1: synchronous, active-high reset.
REQ-005 ID_rR1/ID_rR2 in 5, ID_re1/ID_re2 in 1: ID-stage source registers and their read enables.
REQ-006 ID_EX_rf_we in 1, ID_EX_wR in 5, ID_EX_is_load in 1: EX-stage writer info.
REQ-007 EX_MEM_rf_we in 1, EX_MEM_wR in 5: MEM-stage writer info.
REQ-008 MEM_WB_rf_we in 1, MEM_WB_wR in 5: WB-stage writer info.
REQ-009 EX_branch_taken in 1: redirect resolved in EX.
REQ-010 mem_req in 1, Bus_ready in 1: MEM-stage bus access and completion.
REQ-011 pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall out 1: hold the PC or the named register.
REQ-012 IF_ID_flush, ID_EX_flush, MEM_WB_flush out 1: load a bubble (rf_we=0) into the named register.
REQ-013 fwd_rD1_sel/fwd_rD2_sel out 2: 00 regfile, 01 EX result, 10 MEM result, 11 WB result.
REQ-014 bus_err out 1: one-cycle pulse on bus timeout.
REQ-015 ctrl_state out 2: 00 RUN, 01 LU_STALL, 10 MEM_WAIT.
REQ-016 stat_clr in 1, stall_cnt out CNT_W: stall-cycle counter and synchronous clear.

Function
REQ-017 A RAW match SHALL require read enable=1, writer rf_we=1, equal register index, index != 0.
REQ-018 mem_hold = mem_req & ~Bus_ready & ~timeout_hit: asserts pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_flush; all other flushes forced 0.
REQ-019 If not mem_hold and EX_branch_taken: IF_ID_flush=1, ID_EX_flush=1, no stall, load-use suppressed.
REQ-020 Otherwise, load-use (RAW match vs ID_EX with ID_EX_is_load=1): pc_stall=1, IF_ID_stall=1, ID_EX_flush=1.
REQ-021 Stall and flush outputs SHALL be combinational from inputs and state, same cycle as cause.
REQ-022 FSM: RUN -> MEM_WAIT when mem_hold; MEM_WAIT -> RUN when Bus_ready=1 or timeout_hit; RUN -> LU_STALL on load-use; LU_STALL -> RUN next cycle unless a new cause is present.
REQ-023 Wait counter increments each MEM_WAIT cycle and clears on leaving MEM_WAIT.
REQ-024 timeout_hit = wait counter == MEM_TIMEOUT-1 while mem_req & ~Bus_ready; bus_err=1 for that cycle; the stage advances.
REQ-025 stall_cnt increments each cycle pc_stall=1 and saturates at all-ones.
REQ-026 stat_clr zeroes stall_cnt; clear wins over a same-cycle increment.

Reset
REQ-027 cpu_rst=1 at any cycle: ctrl_state=RUN, wait counter=0, stall_cnt=0 on the next edge.
REQ-028 While cpu_rst=1, all stall, flush, bus_err outputs SHALL be 0 and fwd sels 00; a wait in progress is abandoned.

Configuration
REQ-029 With PIPE_FWD_EN defined: fwd sels = youngest matching writer (EX > MEM > WB), 00 if none; only load-use stalls.
REQ-030 Without PIPE_FWD_EN: fwd sels tied 00; any RAW match vs ID_EX, EX_MEM or MEM_WB stalls as REQ-020 (ctrl_state LU_STALL) until it clears.

Verification
REQ-031 ID_EX load to r5 (is_load=1), ID_rR1=5, re1=1 -> one cycle pc_stall=1, IF_ID_stall=1, ID_EX_flush=1; ctrl_state 01 then 00.
REQ-032 mem_req=1, Bus_ready low 3 cycles -> 3 cycles of stalls + MEM_WB_flush, ctrl_state 10, stall_cnt +3, no bus_err.
REQ-033 mem_req=1, Bus_ready never rises -> bus_err pulses on 16th wait cycle, stalls drop that cycle, ctrl_state returns 00.
REQ-034 EX_branch_taken=1 with load-use pending -> IF_ID_flush=ID_EX_flush=1, pc_stall=0; with mem_hold also present -> stalls only, no flush.
REQ-035 PIPE_FWD_EN: EX_MEM and MEM_WB both write r7, ID_rR2=7 -> fwd_rD2_sel=10; write to r0 -> 00; without macro -> stall.
REQ-036 cpu_rst mid MEM_WAIT -> outputs 0 immediately, RUN and stall_cnt=0 after edge; stat_clr with pc_stall=1 -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW detection, load-use/bus-wait stalls, branch flushes, stall statistics.
// Define PIPE_FWD_EN to enable EX/MEM/WB forwarding (only load-use then stalls).
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic [4:0]       ID_rR1,
  input  logic [4:0]       ID_rR2,
  input  logic             ID_re1,
  input  logic             ID_re2,
  input  logic             ID_EX_rf_we,
  input  logic [4:0]       ID_EX_wR,
  input  logic             ID_EX_is_load,
  input  logic             EX_MEM_rf_we,
  input  logic [4:0]       EX_MEM_wR,
  input  logic             MEM_WB_rf_we,
  input  logic [4:0]       MEM_WB_wR,
  input  logic             EX_branch_taken,
  input  logic             mem_req,
  input  logic             Bus_ready,
  input  logic             stat_clr,
  output logic             pc_stall,
  output logic             IF_ID_stall,
  output logic             ID_EX_stall,
  output logic             EX_MEM_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             MEM_WB_flush,
  output logic [1:0]       fwd_rD1_sel,
  output logic [1:0]       fwd_rD2_sel,
  output logic             bus_err,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_t;

  // The wait counter never exceeds MEM_TIMEOUT-1: that value forces release.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              ex_hit, mem_hit, wb_hit, lu_hit, data_hazard;
  logic              timeout_hit, mem_hold, lu_stall;

  function automatic logic raw_hit(input logic re, input logic [4:0] rr,
                                   input logic we, input logic [4:0] wr);
    return re & we & (rr == wr) & (rr != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic ex, input logic mem, input logic wb);
    if (ex)       return 2'b01;
    else if (mem) return 2'b10;
    else if (wb)  return 2'b11;
    else          return 2'b00;
  endfunction

  assign ex_hit  = raw_hit(ID_re1, ID_rR1, ID_EX_rf_we, ID_EX_wR)
                 | raw_hit(ID_re2, ID_rR2, ID_EX_rf_we, ID_EX_wR);
  assign mem_hit = raw_hit(ID_re1, ID_rR1, EX_MEM_rf_we, EX_MEM_wR)
                 | raw_hit(ID_re2, ID_rR2, EX_MEM_rf_we, EX_MEM_wR);
  assign wb_hit  = raw_hit(ID_re1, ID_rR1, MEM_WB_rf_we, MEM_WB_wR)
                 | raw_hit(ID_re2, ID_rR2, MEM_WB_rf_we, MEM_WB_wR);
  assign lu_hit  = ex_hit & ID_EX_is_load;

`ifdef PIPE_FWD_EN
  assign data_hazard = lu_hit;
  assign fwd_rD1_sel = cpu_rst ? 2'b00 :
    fwd_sel(raw_hit(ID_re1, ID_rR1, ID_EX_rf_we, ID_EX_wR),
            raw_hit(ID_re1, ID_rR1, EX_MEM_rf_we, EX_MEM_wR),
            raw_hit(ID_re1, ID_rR1, MEM_WB_rf_we, MEM_WB_wR));
  assign fwd_rD2_sel = cpu_rst ? 2'b00 :
    fwd_sel(raw_hit(ID_re2, ID_rR2, ID_EX_rf_we, ID_EX_wR),
            raw_hit(ID_re2, ID_rR2, EX_MEM_rf_we, EX_MEM_wR),
            raw_hit(ID_re2, ID_rR2, MEM_WB_rf_we, MEM_WB_wR));
`else
  // Without forwarding every in-flight RAW must wait for write-back.
  assign data_hazard = lu_hit | ex_hit | mem_hit | wb_hit;
  assign fwd_rD1_sel = 2'b00;
  assign fwd_rD2_sel = 2'b00;
`endif

  assign timeout_hit = mem_req & ~Bus_ready & (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  assign mem_hold    = ~cpu_rst & mem_req & ~Bus_ready & ~timeout_hit;
  assign lu_stall    = ~cpu_rst & ~mem_hold & ~EX_branch_taken & data_hazard;
  assign bus_err     = ~cpu_rst & timeout_hit;

  // NOTE: every output gets a default before the priority chain so no latch is inferred.
  always_comb begin
    pc_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    ID_EX_stall  = 1'b0;
    EX_MEM_stall = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    MEM_WB_flush = 1'b0;
    if (mem_hold) begin
      pc_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_EX_stall  = 1'b1;
      EX_MEM_stall = 1'b1;
      MEM_WB_flush = 1'b1;
    end else if (!cpu_rst && EX_branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (lu_stall) begin
      pc_stall    = 1'b1;
      IF_ID_stall = 1'b1;
      ID_EX_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    if (mem_hold)      state_d = ST_MEM_WAIT;
    else if (lu_stall) state_d = ST_LU_STALL;
  end

  // NOTE: registers are updated with non-blocking assignments so all flops sample together.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q  <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= mem_hold ? wait_cnt + 1'b1 : '0;
    end
  end

  // Clear has priority; the counter sticks at all-ones instead of wrapping.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst || stat_clr)
      stall_cnt <= '0;
    else if (pc_stall && !(&stall_cnt))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign ctrl_state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a rule-level model.
module tb_hazard_ctrl;
  localparam int TO    = 16;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rr1 = '0, rr2 = '0, ex_wr = '0, mem_wr = '0, wb_wr = '0;
  logic re1 = 0, re2 = 0, ex_we = 0, ex_ld = 0, mem_we = 0, wb_we = 0;
  logic br = 0, mreq = 0, rdy = 0, clr = 0;

  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic if_id_flush, id_ex_flush, mem_wb_flush, bus_err;
  logic [1:0] sel1, sel2, state;
  logic [CNT_W-1:0] scnt;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .cpu_clk(clk), .cpu_rst(rst),
    .ID_rR1(rr1), .ID_rR2(rr2), .ID_re1(re1), .ID_re2(re2),
    .ID_EX_rf_we(ex_we), .ID_EX_wR(ex_wr), .ID_EX_is_load(ex_ld),
    .EX_MEM_rf_we(mem_we), .EX_MEM_wR(mem_wr),
    .MEM_WB_rf_we(wb_we), .MEM_WB_wR(wb_wr),
    .EX_branch_taken(br), .mem_req(mreq), .Bus_ready(rdy), .stat_clr(clr),
    .pc_stall(pc_stall), .IF_ID_stall(if_id_stall), .ID_EX_stall(id_ex_stall),
    .EX_MEM_stall(ex_mem_stall), .IF_ID_flush(if_id_flush), .ID_EX_flush(id_ex_flush),
    .MEM_WB_flush(mem_wb_flush), .fwd_rD1_sel(sel1), .fwd_rD2_sel(sel2),
    .bus_err(bus_err), .ctrl_state(state), .stall_cnt(scnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: what stalled the pipe last cycle, how long the bus has waited, stall tally.
  int  m_state  = 0;
  int  m_waited = 0;
  int  m_cnt    = 0;
  bit  m_known  = 0;
  bit  m_pc, m_hold, m_lu;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit raw(input bit re, input logic [4:0] rr, input bit we, input logic [4:0] wr);
    return re && we && rr == wr && rr != 0;
  endfunction

  function automatic int pick(input bit ex, input bit mem, input bit wb);
    return ex ? 1 : mem ? 2 : wb ? 3 : 0;
  endfunction

  // Evaluate the rules for the current inputs and compare every output.
  task automatic cycle_begin();
    bit ex_any, mem_any, wb_any, hazard, tmo, br_act;
    int e_sel1, e_sel2;
    bit e_stall4, e_mflush, e_iflush, e_eflush, e_lu_pc;
    #1;
    ex_any  = raw(re1, rr1, ex_we, ex_wr)  || raw(re2, rr2, ex_we, ex_wr);
    mem_any = raw(re1, rr1, mem_we, mem_wr) || raw(re2, rr2, mem_we, mem_wr);
    wb_any  = raw(re1, rr1, wb_we, wb_wr)  || raw(re2, rr2, wb_we, wb_wr);
`ifdef PIPE_FWD_EN
    hazard = ex_any && ex_ld;
    e_sel1 = rst ? 0 : pick(raw(re1, rr1, ex_we, ex_wr), raw(re1, rr1, mem_we, mem_wr), raw(re1, rr1, wb_we, wb_wr));
    e_sel2 = rst ? 0 : pick(raw(re2, rr2, ex_we, ex_wr), raw(re2, rr2, mem_we, mem_wr), raw(re2, rr2, wb_we, wb_wr));
`else
    hazard = ex_any || mem_any || wb_any;
    e_sel1 = 0;
    e_sel2 = 0;
`endif
    tmo    = !rst && mreq && !rdy && m_waited == TO - 1;
    m_hold = !rst && mreq && !rdy && !tmo;
    br_act = !rst && !m_hold && br;
    m_lu   = !rst && !m_hold && !br && hazard;
    e_stall4 = m_hold;
    e_mflush = m_hold;
    e_iflush = br_act;
    e_eflush = br_act || m_lu;
    e_lu_pc  = m_hold || m_lu;
    m_pc     = e_lu_pc;
    check("pc_stall",     pc_stall,     e_lu_pc);
    check("IF_ID_stall",  if_id_stall,  e_lu_pc);
    check("ID_EX_stall",  id_ex_stall,  e_stall4);
    check("EX_MEM_stall", ex_mem_stall, e_stall4);
    check("IF_ID_flush",  if_id_flush,  e_iflush);
    check("ID_EX_flush",  id_ex_flush,  e_eflush);
    check("MEM_WB_flush", mem_wb_flush, e_mflush);
    check("bus_err",      bus_err,      tmo);
    check("fwd_rD1_sel",  sel1,         e_sel1);
    check("fwd_rD2_sel",  sel2,         e_sel2);
    if (m_known) begin
      check("ctrl_state", state, m_state);
      check("stall_cnt",  scnt,  m_cnt);
    end
  endtask

  task automatic cycle_end();
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_waited = 0; m_cnt = 0; m_known = 1;
    end else begin
      m_state  = m_hold ? 2 : m_lu ? 1 : 0;
      m_waited = m_hold ? m_waited + 1 : 0;
      if (clr) m_cnt = 0;
      else if (m_pc && m_cnt < CMAX) m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    cycle_begin();
    cycle_end();
  endtask

  task automatic idle();
    rr1 = 0; rr2 = 0; re1 = 0; re2 = 0;
    ex_we = 0; ex_wr = 0; ex_ld = 0; mem_we = 0; mem_wr = 0; wb_we = 0; wb_wr = 0;
    br = 0; mreq = 0; rdy = 0; clr = 0; rst = 0;
  endtask

  task automatic load_use();
    ex_we = 1; ex_wr = 5; ex_ld = 1; rr1 = 5; re1 = 1;
  endtask

  task automatic rand_inputs(input bit slow);
    rr1 = 5'($urandom_range(0, 7)); rr2 = 5'($urandom_range(0, 7));
    re1 = 1'($urandom); re2 = 1'($urandom);
    ex_we = 1'($urandom); ex_wr = 5'($urandom_range(0, 7)); ex_ld = 1'($urandom);
    mem_we = 1'($urandom); mem_wr = 5'($urandom_range(0, 7));
    wb_we = 1'($urandom); wb_wr = 5'($urandom_range(0, 7));
    br   = ($urandom_range(0, 5) == 0);
    mreq = slow ? 1'b1 : ($urandom_range(0, 2) == 0);
    rdy  = slow ? ($urandom_range(0, 24) == 0) : 1'($urandom);
    clr  = ($urandom_range(0, 399) == 0);
    rst  = ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    @(negedge clk);
    // Reset with a bus wait requested: all control outputs stay low.
    idle(); rst = 1; mreq = 1; load_use();
    cycle_begin();
    check("rst_pc_stall", pc_stall, 0);
    check("rst_mem_wb_flush", mem_wb_flush, 0);
    cycle_end();
    cycle();
    idle();
    cycle_begin();
    check("post_rst_state", state, 0);
    check("post_rst_cnt", scnt, 0);
    cycle_end();

    // Load-use on r5: one stall cycle, then LU_STALL visible.
    load_use();
    cycle_begin();
    check("lu_pc_stall", pc_stall, 1);
    check("lu_if_id_stall", if_id_stall, 1);
    check("lu_id_ex_flush", id_ex_flush, 1);
    cycle_end();
    idle();
    cycle_begin();
    check("lu_state_01", state, 1);
    check("lu_released", pc_stall, 0);
    cycle_end();
    cycle_begin();
    check("lu_state_00", state, 0);
    cycle_end();

    // Three bus-wait cycles from a cleared counter.
    clr = 1; cycle(); idle();
    mreq = 1;
    for (int i = 0; i < 3; i++) begin
      cycle_begin();
      check("wait3_stall", ex_mem_stall, 1);
      check("wait3_mflush", mem_wb_flush, 1);
      check("wait3_no_err", bus_err, 0);
      cycle_end();
    end
    rdy = 1;
    cycle_begin();
    check("wait3_state", state, 2);
    check("wait3_cnt", scnt, 3);
    check("wait3_done", pc_stall, 0);
    cycle_end();

    // Bus never ready: forced release on the 16th wait cycle.
    idle(); mreq = 1;
    for (int i = 1; i <= TO; i++) begin
      cycle_begin();
      if (i < TO) check("tmo_stall", pc_stall, 1);
      else begin
        check("tmo_bus_err", bus_err, 1);
        check("tmo_release", pc_stall, 0);
        check("tmo_state_wait", state, 2);
      end
      cycle_end();
    end
    idle();
    cycle_begin();
    check("tmo_state_run", state, 0);
    cycle_end();

    // Branch beats load-use; bus hold beats branch.
    load_use(); br = 1;
    cycle_begin();
    check("br_pc_stall", pc_stall, 0);
    check("br_if_id_flush", if_id_flush, 1);
    check("br_id_ex_flush", id_ex_flush, 1);
    cycle_end();
    mreq = 1;
    cycle_begin();
    check("hold_br_pc_stall", pc_stall, 1);
    check("hold_br_if_flush", if_id_flush, 0);
    check("hold_br_ex_flush", id_ex_flush, 0);
    cycle_end();
    idle(); cycle();

    // r7 written by both MEM and WB stages; r0 never matches.
    mem_we = 1; mem_wr = 7; wb_we = 1; wb_wr = 7; rr2 = 7; re2 = 1;
    cycle_begin();
`ifdef PIPE_FWD_EN
    check("fwd_r7_sel", sel2, 2);
    check("fwd_r7_nostall", pc_stall, 0);
`else
    check("nofwd_r7_sel", sel2, 0);
    check("nofwd_r7_stall", pc_stall, 1);
`endif
    cycle_end();
    mem_wr = 0; wb_wr = 0; rr2 = 0;
    cycle_begin();
    check("r0_sel", sel2, 0);
    check("r0_nostall", pc_stall, 0);
    cycle_end();
    idle();

    // Reset mid-wait, then clear racing an increment.
    mreq = 1; cycle(); cycle();
    rst = 1;
    cycle_begin();
    check("rst_wait_pc", pc_stall, 0);
    check("rst_wait_mflush", mem_wb_flush, 0);
    cycle_end();
    idle();
    cycle_begin();
    check("rst_wait_state", state, 0);
    check("rst_wait_cnt", scnt, 0);
    cycle_end();
    load_use(); clr = 1;
    cycle_begin();
    check("clr_pc_stall", pc_stall, 1);
    cycle_end();
    idle();
    cycle_begin();
    check("clr_wins", scnt, 0);
    cycle_end();

    // Randomized traffic, alternating fast and slow bus phases.
    for (int i = 0; i < 4000; i++) begin
      rand_inputs(((i / 256) % 2) == 1);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
